// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the pipe_MIPS32 memory arbiter.
package mips32_mem_pkg;

    localparam int DEF_AW       = 10;
    localparam int DEF_DW       = 32;
    localparam int DEF_MAX_WAIT = 4;

    // Which requester owns the read response that returns next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2,
        OWN_DBG  = 2'd3
    } owner_t;

    // Arbiter mode: normal arbitration, one-cycle drain, debug-exclusive.
    typedef enum logic [1:0] {
        ARB    = 2'd0,
        DRAIN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // One-hot grant encoding {dbg, d, if}.
    localparam logic [2:0] GNT_NONE = 3'b000;
    localparam logic [2:0] GNT_IF   = 3'b001;
    localparam logic [2:0] GNT_D    = 3'b010;
    localparam logic [2:0] GNT_DBG  = 3'b100;

    // Map a one-hot grant onto the requester that will own the response.
    function automatic owner_t gnt_to_owner(input logic [2:0] gnt);
        owner_t own;
        case (gnt)
            GNT_IF:  own = OWN_IF;
            GNT_D:   own = OWN_D;
            GNT_DBG: own = OWN_DBG;
            default: own = OWN_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/mips32_prio_sel.sv
// Combinational priority selector: turns the three requests, the IF
// starvation boost and the arbiter mode into a one-hot grant.
module mips32_prio_sel
    import mips32_mem_pkg::*;
(
    input  state_t     state,
    input  logic       boost,
    input  logic       if_req,
    input  logic       d_req,
    input  logic       dbg_req,
    output logic [2:0] gnt
);

    // Fixed priority in ARB (starved IF, data, IF, debug); debug only when locked.
    always_comb begin
        gnt = GNT_NONE;
        case (state)
            ARB: begin
                if (if_req && boost) begin
                    gnt = GNT_IF;
                end else if (d_req) begin
                    gnt = GNT_D;
                end else if (if_req) begin
                    gnt = GNT_IF;
                end else if (dbg_req) begin
                    gnt = GNT_DBG;
                end else begin
                    gnt = GNT_NONE;
                end
            end
            DRAIN: begin
                gnt = GNT_NONE;
            end
            LOCKED: begin
                if (dbg_req) begin
                    gnt = GNT_DBG;
                end else begin
                    gnt = GNT_NONE;
                end
            end
            default: begin
                gnt = GNT_NONE;
            end
        endcase
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port word memory arbiter for the pipe_MIPS32 core: IF, data and
// debug requesters, IF anti-starvation boost and a debug lock mode.
module mips32_mem_arbiter
    import mips32_mem_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          dbg_lock,
    output logic          dbg_locked,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    state_t     state_r;
    state_t     state_next_s;
    owner_t     owner_r;
    logic [3:0] if_wait_r;
    logic       boost_s;
    logic [2:0] sel_gnt_s;
    logic [2:0] gnt_s;
    logic       read_gnt_s;

    assign boost_s = (if_wait_r == MAX_WAIT_L);

    mips32_prio_sel u_prio_sel (
        .state   (state_r),
        .boost   (boost_s),
        .if_req  (if_req),
        .d_req   (d_req),
        .dbg_req (dbg_req),
        .gnt     (sel_gnt_s)
    );

    // Suppress every grant while reset is held.
    always_comb begin
        if (rst) begin
            gnt_s = GNT_NONE;
        end else begin
            gnt_s = sel_gnt_s;
        end
    end

    assign if_gnt  = gnt_s[0];
    assign d_gnt   = gnt_s[1];
    assign dbg_gnt = gnt_s[2];

    // A grant is a read unless the granted requester asserts its write enable.
    assign read_gnt_s = gnt_s[0] | (gnt_s[1] & ~d_we) | (gnt_s[2] & ~dbg_we);

    // Steer the granted request onto the memory port; idle port otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt_s)
            GNT_IF: begin
                mem_en   = 1'b1;
                mem_addr = if_addr;
            end
            GNT_D: begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            GNT_DBG: begin
                mem_en    = 1'b1;
                mem_we    = dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // Mode register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_r <= ARB;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Mode sequencing: ARB -> DRAIN (one cycle) -> LOCKED -> ARB.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ARB: begin
                if (dbg_lock) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = ARB;
                end
            end
            DRAIN: begin
                state_next_s = LOCKED;
            end
            LOCKED: begin
                if (dbg_lock) begin
                    state_next_s = LOCKED;
                end else begin
                    state_next_s = ARB;
                end
            end
            default: begin
                state_next_s = ARB;
            end
        endcase
    end

    // Count consecutive stalled IF cycles, saturating at the boost threshold.
    always_ff @(posedge clk1) begin
        if (rst) begin
            if_wait_r <= 4'd0;
        end else if (!if_req || gnt_s[0]) begin
            if_wait_r <= 4'd0;
        end else if (if_wait_r != MAX_WAIT_L) begin
            if_wait_r <= if_wait_r + 4'd1;
        end else begin
            if_wait_r <= if_wait_r;
        end
    end

    // Remember who owns the read data arriving next cycle.
    always_ff @(posedge clk1) begin
        if (rst) begin
            owner_r <= OWN_NONE;
        end else if (read_gnt_s) begin
            owner_r <= gnt_to_owner(gnt_s);
        end else begin
            owner_r <= OWN_NONE;
        end
    end

    // Response valids follow the owner; a pending response is dropped under reset.
    assign if_rvalid  = !rst && (owner_r == OWN_IF);
    assign d_rvalid   = !rst && (owner_r == OWN_D);
    assign dbg_rvalid = !rst && (owner_r == OWN_DBG);
    assign dbg_locked = !rst && (state_r == LOCKED);

    assign if_rdata  = if_rvalid  ? mem_rdata : '0;
    assign d_rdata   = d_rvalid   ? mem_rdata : '0;
    assign dbg_rdata = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: directed sequences, a cycle
// table and a randomized run against a behavioural reference model.
module tb_mips32_mem_arbiter;

    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          dbg_lock, dbg_locked;
    logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk1 = ~clk1;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk1(clk1), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .dbg_lock(dbg_lock), .dbg_locked(dbg_locked),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port memory macro: one-cycle read latency.
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_in();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        dbg_lock = 1'b0;
    endtask

    // Cycle table: inputs {rst,lock,if,d,dbg,d_we,dbg_we}, expected grants
    // {dbg,d,if}, expected rvalids {dbg,d,if}, expected dbg_locked.
    typedef struct packed {
        logic [6:0] in;
        logic [2:0] gnt;
        logic [2:0] rv;
        logic       lk;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] in, input logic [2:0] g,
                                input logic [2:0] rv, input logic lk);
        vec_t v;
        v.in = in; v.gnt = g; v.rv = rv; v.lk = lk;
        return v;
    endfunction

    vec_t tbl [29];

    // Reference model state
    int            m_state;   // 0 normal, 1 draining, 2 debug-exclusive
    int            m_wait;
    int            m_pend;    // 0 none, 1 IF, 2 D, 3 DBG
    logic [DW-1:0] m_pdata;
    logic          m_pknown;
    logic [DW-1:0] ref_mem [16];
    logic          known   [16];
    int            last_w;

    initial begin
        rst = 1'b1;
        clear_in();

        tbl[0]  = mk(7'b1011100, 3'b000, 3'b000, 1'b0);
        tbl[1]  = mk(7'b1000000, 3'b000, 3'b000, 1'b0);
        tbl[2]  = mk(7'b0000000, 3'b000, 3'b000, 1'b0);
        tbl[3]  = mk(7'b0000100, 3'b100, 3'b000, 1'b0);
        tbl[4]  = mk(7'b0010100, 3'b001, 3'b100, 1'b0);
        tbl[5]  = mk(7'b0011000, 3'b010, 3'b001, 1'b0);
        tbl[6]  = mk(7'b0011000, 3'b010, 3'b010, 1'b0);
        tbl[7]  = mk(7'b0011000, 3'b010, 3'b010, 1'b0);
        tbl[8]  = mk(7'b0011000, 3'b010, 3'b010, 1'b0);
        tbl[9]  = mk(7'b0011000, 3'b001, 3'b010, 1'b0);
        tbl[10] = mk(7'b0011000, 3'b010, 3'b001, 1'b0);
        tbl[11] = mk(7'b0010000, 3'b001, 3'b010, 1'b0);
        tbl[12] = mk(7'b0110000, 3'b001, 3'b001, 1'b0);
        tbl[13] = mk(7'b0111100, 3'b000, 3'b001, 1'b0);
        tbl[14] = mk(7'b0111100, 3'b100, 3'b000, 1'b1);
        tbl[15] = mk(7'b0111101, 3'b100, 3'b100, 1'b1);
        tbl[16] = mk(7'b0011100, 3'b100, 3'b000, 1'b1);
        tbl[17] = mk(7'b0011000, 3'b001, 3'b100, 1'b0);
        tbl[18] = mk(7'b0011000, 3'b010, 3'b001, 1'b0);
        tbl[19] = mk(7'b1011000, 3'b000, 3'b000, 1'b0);
        tbl[20] = mk(7'b0000000, 3'b000, 3'b000, 1'b0);
        tbl[21] = mk(7'b0100000, 3'b000, 3'b000, 1'b0);
        tbl[22] = mk(7'b0000000, 3'b000, 3'b000, 1'b0);
        tbl[23] = mk(7'b0000100, 3'b100, 3'b000, 1'b1);
        tbl[24] = mk(7'b0010100, 3'b001, 3'b100, 1'b0);
        tbl[25] = mk(7'b0101000, 3'b010, 3'b001, 1'b0);
        tbl[26] = mk(7'b0100000, 3'b000, 3'b010, 1'b0);
        tbl[27] = mk(7'b1100100, 3'b000, 3'b000, 1'b0);
        tbl[28] = mk(7'b0001100, 3'b010, 3'b000, 1'b0);

        // Reset with all requests asserted: nothing granted or valid.
        next_cycle();
        if_req = 1'b1; d_req = 1'b1; dbg_req = 1'b1;
        @(negedge clk1);
        chk("reset_gnt", {29'd0, dbg_gnt, d_gnt, if_gnt}, 32'd0);
        chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
        chk("reset_rvalid", {29'd0, dbg_rvalid, d_rvalid, if_rvalid}, 32'd0);
        chk("reset_locked", {31'd0, dbg_locked}, 32'd0);

        // Debug load of word 5, then IF fetch of it.
        next_cycle();
        rst = 1'b0; clear_in();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd5; dbg_wdata = 32'h2842_0001;
        @(negedge clk1);
        chk("dbg_wr_gnt", {31'd0, dbg_gnt}, 32'd1);
        chk("dbg_wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("dbg_wr_addr", {22'd0, mem_addr}, 32'd5);
        chk("dbg_wr_data", mem_wdata, 32'h2842_0001);
        next_cycle();
        clear_in(); if_req = 1'b1; if_addr = 10'd5;
        @(negedge clk1);
        chk("if_rd_gnt", {31'd0, if_gnt}, 32'd1);
        chk("if_rd_mem_en", {31'd0, mem_en}, 32'd1);
        chk("if_rd_mem_we", {31'd0, mem_we}, 32'd0);
        chk("if_rd_addr", {22'd0, mem_addr}, 32'd5);
        next_cycle();
        clear_in();
        @(negedge clk1);
        chk("if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("if_rdata", if_rdata, 32'h2842_0001);
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);

        // Data write then read of the top word.
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3FF; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk1);
        chk("d_wr_gnt", {31'd0, d_gnt}, 32'd1);
        chk("d_wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("d_wr_addr", {22'd0, mem_addr}, 32'h3FF);
        chk("d_wr_data", mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        d_we = 1'b0;
        @(negedge clk1);
        chk("d_rd_gnt", {31'd0, d_gnt}, 32'd1);
        chk("d_rd_mem_we", {31'd0, mem_we}, 32'd0);
        chk("d_wr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        next_cycle();
        clear_in();
        @(negedge clk1);
        chk("d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("d_rdata", d_rdata, 32'hDEAD_BEEF);

        // Debug lock around an in-flight IF read.
        next_cycle();
        dbg_lock = 1'b1; if_req = 1'b1; if_addr = 10'd5;
        @(negedge clk1);
        chk("lock_first_if_gnt", {31'd0, if_gnt}, 32'd1);
        next_cycle();
        @(negedge clk1);
        chk("drain_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("drain_if_rdata", if_rdata, 32'h2842_0001);
        chk("drain_mem_en", {31'd0, mem_en}, 32'd0);
        chk("drain_locked", {31'd0, dbg_locked}, 32'd0);
        next_cycle();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd7; dbg_wdata = 32'hFC00_0000;
        @(negedge clk1);
        chk("locked_flag", {31'd0, dbg_locked}, 32'd1);
        chk("locked_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
        chk("locked_if_stall", {31'd0, if_gnt}, 32'd0);
        chk("locked_mem_we", {31'd0, mem_we}, 32'd1);
        chk("locked_addr", {22'd0, mem_addr}, 32'd7);
        chk("locked_wdata", mem_wdata, 32'hFC00_0000);
        next_cycle();
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
        @(negedge clk1);
        chk("unlock_last_if_stall", {31'd0, if_gnt}, 32'd0);
        chk("unlock_last_locked", {31'd0, dbg_locked}, 32'd1);
        next_cycle();
        if_addr = 10'd7;
        @(negedge clk1);
        chk("arb_again_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("arb_again_locked", {31'd0, dbg_locked}, 32'd0);
        next_cycle();
        clear_in();
        @(negedge clk1);
        chk("if_reads_dbg_word", if_rdata, 32'hFC00_0000);
        chk("if_reads_dbg_valid", {31'd0, if_rvalid}, 32'd1);

        // Cycle table.
        for (int i = 0; i < 29; i++) begin
            next_cycle();
            {rst, dbg_lock, if_req, d_req, dbg_req, d_we, dbg_we} = tbl[i].in;
            if_addr = 10'd1; d_addr = 10'd2; dbg_addr = 10'd3;
            d_wdata = 32'h1111_0000 + 32'(i); dbg_wdata = 32'h2222_0000 + 32'(i);
            @(negedge clk1);
            chk($sformatf("tbl%0d_gnt", i), {29'd0, dbg_gnt, d_gnt, if_gnt}, {29'd0, tbl[i].gnt});
            chk($sformatf("tbl%0d_rvalid", i), {29'd0, dbg_rvalid, d_rvalid, if_rvalid}, {29'd0, tbl[i].rv});
            chk($sformatf("tbl%0d_locked", i), {31'd0, dbg_locked}, {31'd0, tbl[i].lk});
            chk($sformatf("tbl%0d_mem_en", i), {31'd0, mem_en}, {31'd0, |tbl[i].gnt});
        end

        // Randomized run against the reference model.
        next_cycle();
        clear_in(); rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        m_state = 0; m_wait = 0; m_pend = 0; m_pdata = '0; m_pknown = 1'b0; last_w = 0;
        for (int a = 0; a < 16; a++) begin
            known[a] = 1'b0; ref_mem[a] = '0;
        end
        #1;
        for (int c = 0; c < 3000; c++) begin
            int            w;
            logic [2:0]    exp_g;
            logic [2:0]    exp_rv;
            logic          w_we;
            logic [AW-1:0] w_addr;
            logic [DW-1:0] w_data;
            if (c != 0) next_cycle();
            if (!if_req || last_w == 1) begin
                if_req = ($urandom_range(0, 3) != 0);
                if_addr = AW'($urandom_range(0, 15));
            end
            if (!d_req || last_w == 2) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = $urandom_range(0, 1) == 1;
                d_addr = AW'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            if (!dbg_req || last_w == 3) begin
                dbg_req = ($urandom_range(0, 2) == 0);
                dbg_we = $urandom_range(0, 1) == 1;
                dbg_addr = AW'($urandom_range(0, 15));
                dbg_wdata = $urandom;
            end
            if ($urandom_range(0, 31) == 0) dbg_lock = ~dbg_lock;
            @(negedge clk1);

            // Winner from the priority rules of the current mode.
            w = 0;
            if (m_state == 0) begin
                if (if_req && m_wait >= MAX_WAIT) w = 1;
                else if (d_req)                   w = 2;
                else if (if_req)                  w = 1;
                else if (dbg_req)                 w = 3;
            end else if (m_state == 2) begin
                if (dbg_req) w = 3;
            end
            exp_g  = (w == 0) ? 3'b000 : 3'(1 << (w - 1));
            exp_rv = (m_pend == 0) ? 3'b000 : 3'(1 << (m_pend - 1));
            w_we   = (w == 2) ? d_we : (w == 3) ? dbg_we : 1'b0;
            w_addr = (w == 1) ? if_addr : (w == 2) ? d_addr : dbg_addr;
            w_data = (w == 2) ? d_wdata : dbg_wdata;

            chk("rnd_gnt", {29'd0, dbg_gnt, d_gnt, if_gnt}, {29'd0, exp_g});
            chk("rnd_mem_en", {31'd0, mem_en}, {31'd0, w != 0});
            chk("rnd_rvalid", {29'd0, dbg_rvalid, d_rvalid, if_rvalid}, {29'd0, exp_rv});
            chk("rnd_locked", {31'd0, dbg_locked}, {31'd0, m_state == 2});
            if (w != 0) begin
                chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, w_we});
                chk("rnd_mem_addr", {22'd0, mem_addr}, {22'd0, w_addr});
                if (w_we) chk("rnd_mem_wdata", mem_wdata, w_data);
            end
            if (m_pend != 0 && m_pknown) begin
                chk("rnd_rdata",
                    (m_pend == 1) ? if_rdata : (m_pend == 2) ? d_rdata : dbg_rdata,
                    m_pdata);
            end

            // Advance the model by one cycle.
            m_pend = 0;
            if (w != 0 && !w_we) begin
                m_pend   = w;
                m_pknown = known[w_addr[3:0]];
                m_pdata  = ref_mem[w_addr[3:0]];
            end
            if (w != 0 && w_we) begin
                ref_mem[w_addr[3:0]] = w_data;
                known[w_addr[3:0]]   = 1'b1;
            end
            if (if_req && w != 1) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else                  m_wait = 0;
            case (m_state)
                0:       m_state = dbg_lock ? 1 : 0;
                1:       m_state = 2;
                default: m_state = dbg_lock ? 2 : 0;
            endcase
            last_w = w;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
